// File: rtl/trdb_pkg.sv
// Shared types and sizing constants for the trace debugger branch-map path.
package trdb_pkg;

  localparam int unsigned TRDB_BMAP_LEN   = 31;
  localparam int unsigned TRDB_BMAP_CNT_W = 5;

  // Why a branch packet was cut.
  typedef enum logic [1:0] {
    REASON_NONE   = 2'b00,
    REASON_FULL   = 2'b01,
    REASON_FORCED = 2'b10
  } trdb_bm_reason_e;

endpackage : trdb_pkg

// File: rtl/trdb_branch_map_ctrl.sv
// Branch map sequencer: forwards retired branch outcomes into the external
// branch map, mirrors its fill level, snapshots it into a one-entry packet
// slot on a full map or a forced request, and flushes the map a cycle later.
module trdb_branch_map_ctrl
  import trdb_pkg::*;
#(
  parameter int unsigned MAP_LEN = TRDB_BMAP_LEN,
  parameter int unsigned CNT_W   = TRDB_BMAP_CNT_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ivalid_i,
  input  logic               is_branch_i,
  input  logic               branch_taken_i,
  input  logic               flush_req_i,
  output logic               stall_o,
  output logic               bmap_valid_o,
  output logic               bmap_taken_o,
  output logic               bmap_flush_o,
  input  logic [MAP_LEN-1:0] map_i,
  input  logic [CNT_W-1:0]   branches_i,
  output logic               pkt_valid_o,
  input  logic               pkt_ready_i,
  output logic [MAP_LEN-1:0] pkt_map_o,
  output logic [CNT_W-1:0]   pkt_branches_o,
  output logic [1:0]         pkt_reason_o,
  output logic               cnt_err_o
);

  // Index of the last map entry: a branch landing here fills the map.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAP_LEN - 1);

  typedef enum logic {
    SLOT_IDLE,
    SLOT_HOLD
  } slot_state_e;

  slot_state_e       slot_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              flush_pend_q;
  logic [MAP_LEN-1:0] pkt_map_q;
  logic [CNT_W-1:0]  pkt_branches_q;
  trdb_bm_reason_e   reason_q;
  logic              cnt_err_q;

  logic             pkt_valid_q;
  logic [CNT_W-1:0] cnt_eff;
  logic [CNT_W-1:0] cnt_next;
  logic             last_slot_req;
  logic             branch_in;
  logic             full_ev;
  logic             force_ev;
  logic             slot_free;
  logic             emit;

  assign pkt_valid_q = (slot_q == SLOT_HOLD);

  // The map is being cleared this cycle, so its old count no longer applies.
  assign cnt_eff = flush_pend_q ? '0 : cnt_q;

  // Stall is built only from registers and raw inputs so upstream valid can
  // never loop back through it.
  assign last_slot_req = ivalid_i & is_branch_i & (cnt_eff == LAST_IDX);
  assign stall_o       = pkt_valid_q & ~pkt_ready_i & (flush_req_i | last_slot_req);

  assign branch_in = ivalid_i & is_branch_i & ~stall_o;
  assign cnt_next  = cnt_eff + {{(CNT_W-1){1'b0}}, branch_in};
  assign full_ev   = branch_in & (cnt_eff == LAST_IDX);
  assign force_ev  = flush_req_i & (cnt_next != '0);
  assign slot_free = ~pkt_valid_q | pkt_ready_i;
  assign emit      = (full_ev | force_ev) & slot_free;

  assign bmap_valid_o   = branch_in;
  assign bmap_taken_o   = branch_taken_i;
  assign bmap_flush_o   = flush_pend_q;
  assign pkt_valid_o    = pkt_valid_q;
  assign pkt_map_o      = pkt_map_q;
  assign pkt_branches_o = pkt_branches_q;
  assign pkt_reason_o   = reason_q;
  assign cnt_err_o      = cnt_err_q;

  // Packet slot FSM, mirror counter and the delayed map flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    if (!rst_ni) begin
      slot_q         <= SLOT_IDLE;
      cnt_q          <= '0;
      flush_pend_q   <= 1'b0;
      pkt_map_q      <= '0;
      pkt_branches_q <= '0;
      reason_q       <= REASON_NONE;
    end else begin
      flush_pend_q <= emit;
      cnt_q        <= emit ? '0 : cnt_next;

      case (slot_q)
        SLOT_IDLE: if (emit) slot_q <= SLOT_HOLD;
        SLOT_HOLD: if (pkt_ready_i && !emit) slot_q <= SLOT_IDLE;
        default:   slot_q <= SLOT_IDLE;
      endcase

      // The map output already includes this cycle's branch.
      if (emit) begin
        pkt_map_q      <= map_i;
        pkt_branches_q <= branches_i;
        reason_q       <= full_ev ? REASON_FULL : REASON_FORCED;
      end else if (pkt_valid_q && pkt_ready_i) begin
        reason_q <= REASON_NONE;
      end
    end
  end

  // Sticky flag when the map's own count disagrees with the mirror.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_err_q <= 1'b0;
    end else if (!flush_pend_q && (branches_i != cnt_next)) begin
      cnt_err_q <= 1'b1;
    end
  end

endmodule : trdb_branch_map_ctrl

// File: tb/tb_trdb_branch_map_ctrl.sv
// Randomized scoreboard bench for trdb_branch_map_ctrl, with a behavioural
// branch map hung off the DUT's map interface.
module tb_trdb_branch_map_ctrl;
  import trdb_pkg::*;

  localparam int L = 31;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          ivalid_i = 1'b0, is_branch_i = 1'b0, branch_taken_i = 1'b0;
  logic          flush_req_i = 1'b0, pkt_ready_i = 1'b0;
  logic          stall_o, bmap_valid_o, bmap_taken_o, bmap_flush_o;
  logic [L-1:0]  map_i;
  logic [4:0]    branches_i;
  logic          pkt_valid_o;
  logic [L-1:0]  pkt_map_o;
  logic [4:0]    pkt_branches_o;
  logic [1:0]    pkt_reason_o;
  logic          cnt_err_o;

  always #5 clk_i = ~clk_i;

  trdb_branch_map_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ivalid_i(ivalid_i), .is_branch_i(is_branch_i), .branch_taken_i(branch_taken_i),
    .flush_req_i(flush_req_i), .stall_o(stall_o),
    .bmap_valid_o(bmap_valid_o), .bmap_taken_o(bmap_taken_o), .bmap_flush_o(bmap_flush_o),
    .map_i(map_i), .branches_i(branches_i),
    .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i),
    .pkt_map_o(pkt_map_o), .pkt_branches_o(pkt_branches_o),
    .pkt_reason_o(pkt_reason_o), .cnt_err_o(cnt_err_o)
  );

  // Behavioural branch map: bit i = 1 means branch i was not taken; the
  // combinational outputs already reflect the current input and flush.
  logic [L-1:0] map_r;
  logic [4:0]   cnt_r;
  logic [L-1:0] base_map;
  logic [4:0]   base_cnt;

  always_comb begin
    base_map   = bmap_flush_o ? '0 : map_r;
    base_cnt   = bmap_flush_o ? 5'd0 : cnt_r;
    map_i      = base_map;
    branches_i = base_cnt;
    if (bmap_valid_o && base_cnt < 5'd31) begin
      map_i      = base_map | (L'(!bmap_taken_o) << base_cnt);
      branches_i = base_cnt + 5'd1;
    end
  end

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      map_r <= '0;
      cnt_r <= '0;
    end else begin
      map_r <= map_i;
      cnt_r <= branches_i;
    end
  end

  // Scoreboard and checking.
  typedef struct {
    logic [L-1:0] map;
    int           branches;
    logic [1:0]   reason;
  } pkt_t;

  pkt_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level model state: outcomes collected since the last packet.
  bit m_list[$];
  bit m_slot   = 0;
  bit m_flushp = 0;
  int hold_ready = 0;
  bit rnd_ready  = 0;
  int stall_seen = 0;

  function automatic pkt_t make_pkt(input logic [1:0] reason);
    pkt_t p;
    p.map = '0;
    foreach (m_list[i]) p.map[i] = m_list[i];
    p.branches = m_list.size();
    p.reason   = reason;
    return p;
  endfunction

  function automatic logic pick_ready();
    if (hold_ready > 0) begin
      hold_ready--;
      return 1'b0;
    end
    if (rnd_ready) return ($urandom_range(0, 9) < 7);
    return 1'b1;
  endfunction

  // One clock of stimulus plus model update; returns whether it stalled.
  task automatic step(input logic iv, input logic ib, input logic tk,
                      input logic fr, output bit stalled);
    logic rd;
    bit   exp_stall, full, force_, emit;
    @(negedge clk_i);
    rd = pick_ready();
    ivalid_i = iv; is_branch_i = ib; branch_taken_i = tk;
    flush_req_i = fr; pkt_ready_i = rd;
    #1;
    check("pkt_valid", pkt_valid_o, m_slot);
    check("bmap_flush", bmap_flush_o, m_flushp);
    exp_stall = m_slot && !rd && (fr || (iv && ib && m_list.size() == L-1));
    check("stall", stall_o, exp_stall);
    check("bmap_valid", bmap_valid_o, iv && ib && !exp_stall);
    if (bmap_valid_o) check("bmap_taken", bmap_taken_o, tk);
    if (m_slot && rd) m_slot = 0;
    emit = 0;
    if (!exp_stall) begin
      if (iv && ib) m_list.push_back(!tk);
      full   = (m_list.size() == L);
      force_ = fr && (m_list.size() != 0);
      emit   = full || force_;
      if (emit) begin
        exp_q.push_back(make_pkt(full ? 2'b01 : 2'b10));
        m_list.delete();
        m_slot = 1;
      end
    end else begin
      stall_seen++;
    end
    m_flushp = emit;
    stalled  = exp_stall;
  endtask

  // Issue one retirement, holding it while the DUT stalls (bounded).
  task automatic retire(input logic iv, input logic ib, input logic tk, input logic fr);
    bit st;
    int n = 0;
    do begin
      step(iv, ib, tk, fr, st);
      n++;
    end while (st && n < 200);
    if (st) check("stall_timeout", 1, 0);
  endtask

  // Monitor: pops an expected packet at every accepted handshake.
  initial begin
    pkt_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_ni && pkt_valid_o && pkt_ready_i) begin
        if (exp_q.size() == 0) begin
          check("pkt_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pkt_map", pkt_map_o, e.map);
          check("pkt_branches", pkt_branches_o, e.branches);
          check("pkt_reason", pkt_reason_o, e.reason);
        end
      end else if (rst_ni && !pkt_valid_o) begin
        check("reason_idle", pkt_reason_o, 2'b00);
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_stall"}, stall_o, 0);
    check({tag, "_bvalid"}, bmap_valid_o, 0);
    check({tag, "_btaken"}, bmap_taken_o, 0);
    check({tag, "_bflush"}, bmap_flush_o, 0);
    check({tag, "_pvalid"}, pkt_valid_o, 0);
    check({tag, "_pmap"}, pkt_map_o, 0);
    check({tag, "_pbr"}, pkt_branches_o, 0);
    check({tag, "_preason"}, pkt_reason_o, 0);
    check({tag, "_cnterr"}, cnt_err_o, 0);
  endtask

  initial begin
    bit st;
    int n;
    #3;
    check_outputs_zero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // 31 taken branches with ready high: FULL packet, map all zeros.
    for (int i = 0; i < L; i++) retire(1, 1, 1, 0);
    // Branch in the flush cycle lands in map[0].
    retire(1, 1, 0, 0);
    check("cnt_after_flush_branch", branches_i, 5'd1);
    retire(0, 0, 0, 1);

    // taken, not taken, taken, then forced flush: map 3'b010.
    retire(1, 1, 1, 0);
    retire(1, 1, 0, 0);
    retire(1, 1, 1, 0);
    retire(0, 0, 0, 1);
    retire(0, 0, 0, 0);

    // Forced request on an empty map: nothing happens.
    retire(0, 0, 0, 1);
    retire(0, 0, 0, 0);

    // Held packet while the next map fills: the 31st branch stalls.
    for (int i = 0; i < L; i++) retire(1, 1, i[0], 0);
    n = stall_seen;
    hold_ready = 40;
    for (int i = 0; i < L; i++) retire(1, 1, i[1], 0);
    check("stall_observed", stall_seen > n, 1);
    retire(0, 0, 0, 0);
    retire(0, 0, 0, 0);

    // Reset while a packet is held.
    retire(1, 1, 0, 0);
    hold_ready = 3;
    retire(0, 0, 0, 1);
    step(0, 0, 0, 0, st);
    check("pre_reset_valid", pkt_valid_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    m_list.delete();
    m_slot = 0;
    m_flushp = 0;
    hold_ready = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) retire(1, 1, 0, 0);
    retire(0, 0, 0, 1);
    retire(0, 0, 0, 0);

    // Randomized traffic with random backpressure.
    rnd_ready = 1;
    for (int i = 0; i < 2500; i++) begin
      int fr_mod;
      fr_mod = (i < 1200) ? 80 : 10;
      retire($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
             $urandom_range(0, 1), $urandom_range(0, fr_mod - 1) == 0);
    end

    // Drain.
    rnd_ready = 0;
    retire(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) retire(0, 0, 0, 0);
    check("queue_empty", exp_q.size(), 0);
    check("cnt_err_final", cnt_err_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_trdb_branch_map_ctrl
